// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-source result FIFOs feeding one
// registered round-robin broadcast per cycle.
package cdb_pkg;
  typedef struct packed {
    logic [4:0]  reg_id;
    logic [31:0] data;
  } cmd_buf_t;
endpackage

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int NSRC  = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [36:0] cmd_buf_alu,
  input  logic [36:0] cmd_buf_ld_str,
  input  logic [36:0] cmd_buf_mul,
  input  logic [36:0] cmd_buf_div,
  input  logic [36:0] cmd_buf_cmp,
  input  logic        cdb_ready,
  input  logic        flush,
  output logic [36:0] cdb_o,
  output logic [4:0]  src_full_o,
  output logic        overflow_o,
  output logic        busy_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = $clog2(NSRC);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  cmd_buf_t        in_c [NSRC];
  cmd_buf_t        mem [NSRC][DEPTH];
  logic [AW-1:0]   wr_ptr [NSRC];
  logic [AW-1:0]   rd_ptr [NSRC];
  logic [AW:0]     cnt [NSRC];
  logic [NSRC-1:0] in_vld;
  logic [NSRC-1:0] nonempty;
  logic [NSRC-1:0] push;
  logic [NSRC-1:0] pop;
  logic [NSRC-1:0] drop;
  logic [SW-1:0]   rr_ptr;
  logic [SW-1:0]   gnt_idx;
  logic            gnt_vld;
  logic            arb_en;
  cmd_buf_t        cdb_q;

  // (a + k) mod NSRC, valid for a, k < NSRC
  function automatic logic [SW-1:0] wrap_add(
    input logic [SW-1:0] a,
    input int            k
  );
    int s;
    s = int'(a) + k;
    if (s >= NSRC) s = s - NSRC;
    return SW'(s);
  endfunction

  assign in_c[0] = cmd_buf_t'(cmd_buf_alu);
  assign in_c[1] = cmd_buf_t'(cmd_buf_ld_str);
  assign in_c[2] = cmd_buf_t'(cmd_buf_mul);
  assign in_c[3] = cmd_buf_t'(cmd_buf_div);
  assign in_c[4] = cmd_buf_t'(cmd_buf_cmp);

  always_comb begin
    in_vld     = '0;
    nonempty   = '0;
    src_full_o = '0;
    for (int i = 0; i < NSRC; i++) begin
      in_vld[i]     = in_c[i].reg_id != '0;
      nonempty[i]   = cnt[i] != '0;
      src_full_o[i] = cnt[i] == FULL;
    end
  end

  always_comb begin
    arb_en  = cdb_ready && !flush;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NSRC; k++) begin
      if (!gnt_vld && nonempty[wrap_add(rr_ptr, k)]) begin
        gnt_vld = 1'b1;
        gnt_idx = wrap_add(rr_ptr, k);
      end
    end
  end

  // A pop frees the slot in the same cycle, so a full FIFO still accepts
  always_comb begin
    pop  = '0;
    push = '0;
    drop = '0;
    for (int i = 0; i < NSRC; i++) begin
      pop[i]  = arb_en && gnt_vld && (gnt_idx == SW'(i));
      push[i] = in_vld[i] && !flush &&
                (!src_full_o[i] || pop[i]);
      drop[i] = in_vld[i] && !flush &&
                src_full_o[i] && !pop[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NSRC; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= in_c[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr     <= '0;
      cdb_q      <= '0;
      overflow_o <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < NSRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      rr_ptr <= '0;
      cdb_q  <= '0;
    end else begin
      for (int i = 0; i < NSRC; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
        unique case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + 1'b1;
          2'b01:   cnt[i] <= cnt[i] - 1'b1;
          default: cnt[i] <= cnt[i];
        endcase
      end
      if (arb_en && gnt_vld) begin
        cdb_q  <= mem[gnt_idx][rd_ptr[gnt_idx]];
        rr_ptr <= wrap_add(gnt_idx, 1);
      end else begin
        cdb_q <= '0;
      end
      if (|drop) overflow_o <= 1'b1;
    end
  end

  assign cdb_o  = cdb_q;
  assign busy_o = (|nonempty) || (cdb_q.reg_id != '0);

endmodule
